// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the lfsr_bank generator.
// Contents: FSM state enum, golden-ratio seed spreading constant,
//           tap-mask lookup per LFSR width, default per-channel seed function.
package lfsr_pkg;

    typedef enum logic {ST_WARMUP = 1'b0, ST_RUN = 1'b1} lfsr_state_t;

    localparam logic [63:0] GOLDEN = 64'h9E37_79B9_7F4A_7C15;

    // Maximal-length XOR taps, bit i set for 1-based tap i+1.
    function automatic logic [63:0] taps_for_width(input int width);
        return width == 8  ? 64'h0000_0000_0000_00B8 :
               width == 16 ? 64'h0000_0000_0000_D008 :
               width == 32 ? 64'h0000_0000_8020_0003 :
               width == 64 ? 64'hD800_0000_0000_0000 : 64'h0;
    endfunction

    function automatic logic [63:0] width_mask(input int width);
        return width >= 64 ? '1 : (64'd1 << width) - 64'd1;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [63:0] default_seed(input logic [63:0] seed, input int c, input int width);
        logic [63:0] v;
        v = (seed ^ (64'(c) * GOLDEN)) & width_mask(width);
        return v == 64'd0 ? width_mask(width) : v;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: one Fibonacci LFSR channel with parallel load.
// Ports: CLK clock; load loads load_val (wins over step); step shifts one
//        position with XOR feedback of the TAPMASK bits; state is the register.
module lfsr_core import lfsr_pkg::*; #(
    parameter int WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPMASK = WIDTH'(taps_for_width(WIDTH))
) (
    input  logic             CLK,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge CLK) begin
        if (load)
            state <= load_val;
        else if (step)
            state <= {state[WIDTH-2:0], ^(state & TAPMASK)};
    end

endmodule

// File: rtl/lfsr_bank.sv
// lfsr_bank: NCH independent WIDTH-bit Fibonacci LFSRs with reseed, step enable,
//            post-seed warm-up and valid flag.
// Ports: CLK clock; nRST synchronous active-low reset; en steps all channels in RUN;
//        seed_we/seed_ch/seed_data reseed one channel; r packed channel states;
//        bit_out per-channel MSB; valid outputs usable; lockup_seen sticky zero-state flag.
// Option: define LFSR_LOCKUP_RECOVER_EN to reload zero-state channels and set lockup_seen.
module lfsr_bank import lfsr_pkg::*; #(
    parameter int          WIDTH  = 64,
    parameter int          NCH    = 4,
    parameter logic [63:0] SEED   = 64'hFEED_BABE_DEAD_BEEF,
    parameter int          WARMUP = 16,
    localparam int         CW     = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 en,
    input  logic                 seed_we,
    input  logic [CW-1:0]        seed_ch,
    input  logic [WIDTH-1:0]     seed_data,
    output logic [NCH*WIDTH-1:0] r,
    output logic [NCH-1:0]       bit_out,
    output logic                 valid,
    output logic                 lockup_seen
);

    localparam int CNTW = WARMUP > 1 ? $clog2(WARMUP) : 1;
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_for_width(WIDTH));

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("lfsr_bank: WIDTH must be 8, 16, 32 or 64");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("lfsr_bank: NCH must be at least 1");
    end
    if (WARMUP < 0) begin : g_bad_warmup
        $error("lfsr_bank: WARMUP must not be negative");
    end

    lfsr_state_t     st, st_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic            seed_hit;
    logic            step_all;
    logic [NCH-1:0]  recover;

    assign seed_hit = seed_we && (32'(seed_ch) < NCH);
    assign step_all = st == ST_WARMUP || en;
    assign valid    = st == ST_RUN;

    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        if (seed_hit) begin
            st_nx  = WARMUP == 0 ? ST_RUN : ST_WARMUP;
            cnt_nx = '0;
        end else if (st == ST_WARMUP) begin
            st_nx  = cnt == CNTW'(WARMUP - 1) ? ST_RUN : ST_WARMUP;
            cnt_nx = cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            st  <= WARMUP == 0 ? ST_RUN : ST_WARMUP;
            cnt <= '0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [WIDTH-1:0] DSEED = WIDTH'(default_seed(SEED, c, WIDTH));
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] load_val;
        logic             hit;
        logic             load;
        assign hit = seed_hit && 32'(seed_ch) == c;
`ifdef LFSR_LOCKUP_RECOVER_EN
        // A reseed of this channel already clears the lockup, so it is not counted.
        assign recover[c] = s == '0 && !hit;
`else
        assign recover[c] = 1'b0;
`endif
        assign load     = !nRST || hit || recover[c];
        assign load_val = nRST && hit ? (seed_data == '0 ? '1 : seed_data) : DSEED;
        lfsr_core #(.WIDTH(WIDTH), .TAPMASK(TAPS)) u_core (
            .CLK      (CLK),
            .load     (load),
            .load_val (load_val),
            .step     (step_all),
            .state    (s)
        );
        assign r[c*WIDTH +: WIDTH] = s;
        assign bit_out[c]          = s[WIDTH-1];
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    always_ff @(posedge CLK) begin
        if (!nRST)
            lockup_seen <= 1'b0;
        else if (|recover)
            lockup_seen <= 1'b1;
    end
`else
    assign lockup_seen = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// tb_lfsr_bank: self-checking bench for lfsr_bank using three configurations
// (64-bit/1ch/no warm-up, 8-bit/1ch/no warm-up, 16-bit/4ch/16-step warm-up).
module tb_lfsr_bank;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int errs = 0;
    int checks = 0;
    logic [63:0] q[$];
    logic [15:0] mc[4];

    logic en_a = 0, swe_a = 0, v_a, lk_a;
    logic [0:0] sch_a = '0, bo_a;
    logic [63:0] sd_a = '0, r_a;

    logic en_b = 0, swe_b = 0, v_b, lk_b;
    logic [0:0] sch_b = '0, bo_b;
    logic [7:0] sd_b = '0, r_b;

    logic en_c = 0, swe_c = 0, v_c, lk_c;
    logic [1:0] sch_c = '0;
    logic [3:0] bo_c;
    logic [15:0] sd_c = '0;
    logic [63:0] r_c;

    lfsr_bank #(.WIDTH(64), .NCH(1), .WARMUP(0)) u_a (
        .CLK(CLK), .nRST(nRST), .en(en_a), .seed_we(swe_a), .seed_ch(sch_a), .seed_data(sd_a),
        .r(r_a), .bit_out(bo_a), .valid(v_a), .lockup_seen(lk_a));

    lfsr_bank #(.WIDTH(8), .NCH(1), .WARMUP(0)) u_b (
        .CLK(CLK), .nRST(nRST), .en(en_b), .seed_we(swe_b), .seed_ch(sch_b), .seed_data(sd_b),
        .r(r_b), .bit_out(bo_b), .valid(v_b), .lockup_seen(lk_b));

    lfsr_bank #(.WIDTH(16), .NCH(4), .WARMUP(16)) u_c (
        .CLK(CLK), .nRST(nRST), .en(en_c), .seed_we(swe_c), .seed_ch(sch_c), .seed_data(sd_c),
        .r(r_c), .bit_out(bo_c), .valid(v_c), .lockup_seen(lk_c));

    function automatic logic [63:0] wmask(input int w);
        return w == 64 ? '1 : (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] mstep(input logic [63:0] s, input int w);
        logic [63:0] t;
        t = w == 8 ? 64'hB8 : w == 16 ? 64'hD008 : w == 32 ? 64'h8020_0003 : 64'hD800_0000_0000_0000;
        return ((s << 1) | {63'd0, ^(s & t)}) & wmask(w);
    endfunction

    function automatic logic [63:0] dseed(input int c, input int w);
        logic [63:0] v;
        v = (64'hFEED_BABE_DEAD_BEEF ^ (64'(c) * 64'h9E37_79B9_7F4A_7C15)) & wmask(w);
        return v == 0 ? wmask(w) : v;
    endfunction

    function automatic logic [63:0] pack_c();
        return {mc[3], mc[2], mc[1], mc[0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 0;
        {en_a, en_b, en_c, swe_a, swe_b, swe_c} = '0;
        tick();
        nRST = 1;
        for (int c = 0; c < 4; c++) mc[c] = 16'(dseed(c, 16));
    endtask

    task automatic step_mc();
        for (int c = 0; c < 4; c++) mc[c] = 16'(mstep(64'(mc[c]), 16));
    endtask

    task automatic warm_check(input string name);
        logic [63:0] e;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                step_mc();
                tick();
            end
            checks++;
            if (v_c !== (i == 16)) begin
                errs++;
                $display("FAIL %s valid after %0d edges: got %b want %b", name, i, v_c, i == 16);
            end
        end
        q.push_back(pack_c());
        e = q.pop_front();
        checks++;
        if (r_c !== e) begin
            errs++;
            $display("FAIL %s state: got %h want %h", name, r_c, e);
        end
        checks++;
        if (bo_c !== {mc[3][15], mc[2][15], mc[1][15], mc[0][15]}) begin
            errs++;
            $display("FAIL %s bit_out: got %b want %b", name, bo_c, {mc[3][15], mc[2][15], mc[1][15], mc[0][15]});
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (r_a !== 64'hFEED_BABE_DEAD_BEEF) begin errs++; $display("FAIL reset r64: got %h want FEEDBABEDEADBEEF", r_a); end
        checks++;
        if (v_a !== 1'b1) begin errs++; $display("FAIL reset valid64: got %b want 1", v_a); end
        checks++;
        if (bo_a !== 1'b1) begin errs++; $display("FAIL reset bit_out64: got %b want 1", bo_a); end
        checks++;
        if (r_b !== 8'hEF) begin errs++; $display("FAIL reset r8: got %h want ef", r_b); end
        checks++;
        if (r_c !== pack_c()) begin errs++; $display("FAIL reset r16: got %h want %h", r_c, pack_c()); end
        checks++;
        if (v_c !== 1'b0) begin errs++; $display("FAIL reset valid16: got %b want 0", v_c); end
        checks++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin errs++; $display("FAIL reset lockup: got %b want 000", {lk_a, lk_b, lk_c}); end
    endtask

    task automatic test_step64();
        logic [63:0] e, x;
        do_reset();
        en_a = 1;
        e = 64'hFEED_BABE_DEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            e = mstep(e, 64);
            q.push_back(e);
            tick();
            x = q.pop_front();
            checks++;
            if (r_a !== x || v_a !== 1'b1) begin errs++; $display("FAIL step64 #%0d: got %h/%b want %h/1", i, r_a, v_a, x); end
            if (i == 0) begin
                checks++;
                if (r_a !== 64'hFDDB_757D_BD5B_7DDE) begin errs++; $display("FAIL step64 first: got %h want FDDB757DBD5B7DDE", r_a); end
            end
        end
        en_a = 0;
        for (int i = 0; i < 10; i++) begin
            q.push_back(e);
            tick();
            x = q.pop_front();
            checks++;
            if (r_a !== x) begin errs++; $display("FAIL hold64 #%0d: got %h want %h", i, r_a, x); end
        end
        swe_a = 1; sch_a = 1'b1; sd_a = 64'h1234;
        tick();
        swe_a = 0;
        checks++;
        if (r_a !== e || v_a !== 1'b1) begin errs++; $display("FAIL bad_ch: got %h/%b want %h/1", r_a, v_a, e); end
        swe_a = 1; sch_a = 1'b0; sd_a = 64'h0;
        tick();
        swe_a = 0;
        checks++;
        if (r_a !== '1 || v_a !== 1'b1) begin errs++; $display("FAIL seed_zero64: got %h/%b want ffffffffffffffff/1", r_a, v_a); end
    endtask

    task automatic test_period8();
        bit seen[256];
        logic [7:0] tbl[5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        logic [63:0] x;
        int n;
        bit rep;
        do_reset();
        swe_b = 1; sch_b = 1'b0; sd_b = 8'h01;
        tick();
        swe_b = 0;
        checks++;
        if (r_b !== 8'h01 || v_b !== 1'b1) begin errs++; $display("FAIL seed8: got %h/%b want 01/1", r_b, v_b); end
        foreach (tbl[i]) q.push_back(64'(tbl[i]));
        foreach (seen[i]) seen[i] = 0;
        seen[1] = 1;
        n = 0;
        rep = 0;
        en_b = 1;
        while (n < 300) begin
            tick();
            n++;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (r_b !== x[7:0]) begin errs++; $display("FAIL seq8 #%0d: got %h want %h", n, r_b, x[7:0]); end
            end
            if (r_b == 8'h01) break;
            if (seen[r_b]) rep = 1;
            seen[r_b] = 1;
        end
        en_b = 0;
        checks++;
        if (n != 255) begin errs++; $display("FAIL period8: got %0d want 255", n); end
        checks++;
        if (rep) begin errs++; $display("FAIL repeat8: got repeat want none"); end
    endtask

    task automatic test_warmup();
        do_reset();
        warm_check("warmup");
    endtask

    task automatic test_reseed_run();
        logic [63:0] x;
        en_c = 1; swe_c = 1; sch_c = 2'd2; sd_c = 16'h1234;
        step_mc();
        mc[2] = 16'h1234;
        q.push_back(pack_c());
        tick();
        swe_c = 0; en_c = 0;
        x = q.pop_front();
        checks++;
        if (r_c !== x) begin errs++; $display("FAIL reseed_run state: got %h want %h", r_c, x); end
        warm_check("reseed_run");
        for (int i = 0; i < 10; i++) begin
            q.push_back(pack_c());
            tick();
            x = q.pop_front();
            checks++;
            if (r_c !== x) begin errs++; $display("FAIL hold16 #%0d: got %h want %h", i, r_c, x); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin step_mc(); tick(); end
        swe_c = 1; sch_c = 2'd0; sd_c = 16'h0;
        step_mc();
        mc[0] = 16'hFFFF;
        tick();
        swe_c = 0;
        warm_check("reseed_warm");
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        for (int i = 0; i < 3; i++) begin step_mc(); tick(); end
        do_reset();
        warm_check("reset_mid_warm");
    endtask

    task automatic test_lockup();
`ifdef LFSR_LOCKUP_RECOVER_EN
        u_c.g_ch[1].u_core.state = 16'h0;
        mc[1] = 16'(dseed(1, 16));
        tick();
        checks++;
        if (r_c !== pack_c() || lk_c !== 1'b1) begin errs++; $display("FAIL lockup reload: got %h/%b want %h/1", r_c, lk_c, pack_c()); end
        tick();
        tick();
        checks++;
        if (lk_c !== 1'b1) begin errs++; $display("FAIL lockup sticky: got %b want 1", lk_c); end
        do_reset();
        checks++;
        if (lk_c !== 1'b0) begin errs++; $display("FAIL lockup clear: got %b want 0", lk_c); end
`else
        tick();
        checks++;
        if ({lk_a, lk_b, lk_c} !== 3'b000) begin errs++; $display("FAIL lockup tied: got %b want 000", {lk_a, lk_b, lk_c}); end
`endif
    endtask

    initial begin
        test_reset();
        test_step64();
        test_period8();
        test_warmup();
        test_reseed_run();
        test_back_to_back();
        test_lockup();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
